ex_stage: RTL and testbench

- Execute stage of the team's single-issue MIPS pipeline, sitting between the ID/EX register and the memory stage.
- Accepts one decoded instruction per handshake and derives ALU operands and the 4-bit ALUop for the combinational ALU, which sits outside this block and connects through the alu_* ports.
- Captures the ALU outputs into a registered EX/MEM bundle with valid/ready flow control.
- Signed-overflow traps halt the stage until a flush.

---
 rtl/ex_stage.sv | 210 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage: operand/ALUop decode for the external ALU
// and a registered EX/MEM bundle with valid/ready flow control.
module ex_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_opcode,
  input  logic [5:0]            in_funct,
  input  logic [4:0]            in_shamt,
  input  logic [15:0]           in_imm,
  input  logic [DATA_WIDTH-1:0] in_rs_val,
  input  logic [DATA_WIDTH-1:0] in_rt_val,
  input  logic [4:0]            in_dest,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [3:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_Zero,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_dest,
  output logic                  out_is_mem,
  output logic                  out_branch_taken,
  output logic                  out_trap
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [4:0]            dest;
    logic                  is_mem;
    logic                  branch_taken;
    logic                  trap;
  } ex_mem_t;

  state_t  state, state_nx;
  ex_mem_t out_q, out_d;
  logic    out_v;
  logic    xfer;

  logic [DATA_WIDTH-1:0] simm, zimm, loc_val;
  logic use_loc, trap_en, is_mem, is_beq, is_bne;

  assign simm = {{(DATA_WIDTH-16){in_imm[15]}}, in_imm};
  assign zimm = {{(DATA_WIDTH-16){1'b0}}, in_imm};

  always_comb begin
    alu_A     = in_rs_val;
    alu_B     = '0;
    alu_ALUop = OP_ADD;
    use_loc   = 1'b0;
    loc_val   = '0;
    trap_en   = 1'b0;
    is_mem    = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    unique case (1'b1)
      in_opcode == 6'b000000: begin
        alu_B = in_rt_val;
        case (in_funct)
          6'b100000: trap_en = 1'b1;
          6'b100001: ;
          6'b100010: begin
            alu_ALUop = OP_SUB;
            trap_en   = 1'b1;
          end
          6'b100011: alu_ALUop = OP_SUB;
          6'b100100: alu_ALUop = OP_AND;
          6'b100101: alu_ALUop = OP_OR;
          6'b100110: alu_ALUop = OP_XOR;
          6'b101010: alu_ALUop = OP_SLT;
          6'b101011: begin
            use_loc = 1'b1;
            loc_val = {{(DATA_WIDTH-1){1'b0}},
                       in_rs_val < in_rt_val};
          end
          6'b000000: begin
            alu_A     = {{(DATA_WIDTH-5){1'b0}}, in_shamt};
            alu_ALUop = OP_SLL;
          end
          6'b000010: begin
            alu_A     = {{(DATA_WIDTH-5){1'b0}}, in_shamt};
            alu_ALUop = OP_SRL;
          end
          6'b000011: begin
            alu_A     = {{(DATA_WIDTH-5){1'b0}}, in_shamt};
            alu_ALUop = OP_SRA;
          end
          6'b000100: alu_ALUop = OP_SLL;
          6'b000110: alu_ALUop = OP_SRL;
          6'b000111: alu_ALUop = OP_SRA;
          default:   alu_B = '0;
        endcase
      end
      in_opcode == 6'b001000: begin
        alu_B   = simm;
        trap_en = 1'b1;
      end
      in_opcode == 6'b001001: alu_B = simm;
      in_opcode == 6'b001010: begin
        alu_B     = simm;
        alu_ALUop = OP_SLT;
      end
      in_opcode == 6'b001011: begin
        alu_B   = simm;
        use_loc = 1'b1;
        loc_val = {{(DATA_WIDTH-1){1'b0}}, in_rs_val < simm};
      end
      in_opcode == 6'b001100: begin
        alu_B     = zimm;
        alu_ALUop = OP_AND;
      end
      in_opcode == 6'b001101: begin
        alu_B     = zimm;
        alu_ALUop = OP_OR;
      end
      in_opcode == 6'b001110: begin
        alu_B     = zimm;
        alu_ALUop = OP_XOR;
      end
      in_opcode == 6'b001111: begin
        alu_A     = DATA_WIDTH'(16);
        alu_B     = zimm;
        alu_ALUop = OP_SLL;
      end
      in_opcode == 6'b100011,
      in_opcode == 6'b101011: begin
        alu_B  = simm;
        is_mem = 1'b1;
      end
      in_opcode == 6'b000100: begin
        alu_B     = in_rt_val;
        alu_ALUop = OP_SUB;
        is_beq    = 1'b1;
      end
      in_opcode == 6'b000101: begin
        alu_B     = in_rt_val;
        alu_ALUop = OP_SUB;
        is_bne    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_d.result       = use_loc ? loc_val : alu_Result;
    out_d.dest         = in_dest;
    out_d.is_mem       = is_mem;
    out_d.branch_taken = (is_beq & alu_Zero) | (is_bne & ~alu_Zero);
    out_d.trap         = trap_en & alu_Overflow;
  end

  assign in_ready = (state == RUN) && (!out_v || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    if (flush)
      state_nx = RUN;
    else if (xfer && out_d.trap)
      state_nx = HALT;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nx;
  end

  // flush outranks a same-cycle transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
    end else if (xfer) begin
      out_v <= 1'b1;
      out_q <= out_d;
    end else if (out_ready) begin
      out_v <= 1'b0;
    end
  end

  assign out_valid        = out_v;
  assign out_result       = out_q.result;
  assign out_dest         = out_q.dest;
  assign out_is_mem       = out_q.is_mem;
  assign out_branch_taken = out_q.branch_taken;
  assign out_trap         = out_q.trap;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: reference ALU, vector table, scoreboard
// and hand sequences for trap/halt, backpressure and reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic [4:0]  in_dest = '0;
  logic [31:0] alu_A, alu_B;
  logic [3:0]  alu_ALUop;
  logic [31:0] alu_Result;
  logic        alu_Overflow, alu_Zero;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_is_mem, out_branch_taken, out_trap;

  ex_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_dest(in_dest),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
    .alu_Zero(alu_Zero), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .out_is_mem(out_is_mem),
    .out_branch_taken(out_branch_taken),
    .out_trap(out_trap)
  );

  always #5 clk = ~clk;

  // reference ALU sitting outside the stage
  always_comb begin
    alu_Result   = '0;
    alu_Overflow = 1'b0;
    case (alu_ALUop)
      4'b0000: alu_Result = alu_A & alu_B;
      4'b0001: alu_Result = alu_A | alu_B;
      4'b0010: begin
        alu_Result   = alu_A + alu_B;
        alu_Overflow = (alu_A[31] == alu_B[31]) &&
                       (alu_Result[31] != alu_A[31]);
      end
      4'b0110: begin
        alu_Result   = alu_A - alu_B;
        alu_Overflow = (alu_A[31] != alu_B[31]) &&
                       (alu_Result[31] != alu_A[31]);
      end
      4'b0111: alu_Result = {31'b0, $signed(alu_A) < $signed(alu_B)};
      4'b0011: alu_Result = alu_B << alu_A[4:0];
      4'b0100: alu_Result = $unsigned($signed(alu_B) >>> alu_A[4:0]);
      4'b0101: alu_Result = alu_B >> alu_A[4:0];
      4'b1000: alu_Result = alu_A ^ alu_B;
      default: alu_Result = '0;
    endcase
  end
  assign alu_Zero = (alu_Result == 32'd0);

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] a;
    logic [3:0]  aop;
    logic        chk_alu;
    logic [31:0] res;
    logic        chk_res;
    logic        mem;
    logic        br;
    logic        trap;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic [4:0]  dest;
    logic        mem;
    logic        br;
    logic        trap;
  } exp_t;

  int   checks = 0;
  int   passed = 0;
  exp_t q[$];
  exp_t e;
  vec_t vt[20];
  vec_t vtrap, vb;

  function automatic vec_t mk(
    logic [5:0] op, logic [5:0] fn, logic [4:0] sh,
    logic [15:0] imm, logic [31:0] rs, logic [31:0] rt,
    logic [31:0] a, logic [3:0] aop, logic chk_alu,
    logic [31:0] res, logic chk_res,
    logic mem, logic br, logic trap);
    vec_t v;
    v.op = op; v.fn = fn; v.sh = sh; v.imm = imm;
    v.rs = rs; v.rt = rt; v.a = a; v.aop = aop;
    v.chk_alu = chk_alu; v.res = res; v.chk_res = chk_res;
    v.mem = mem; v.br = br; v.trap = trap;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  task automatic drive(vec_t v, logic [4:0] d);
    in_opcode = v.op;
    in_funct  = v.fn;
    in_shamt  = v.sh;
    in_imm    = v.imm;
    in_rs_val = v.rs;
    in_rt_val = v.rt;
    in_dest   = d;
    in_valid  = 1'b1;
  endtask

  // called at posedge+1; returns at the next posedge+1
  task automatic send(vec_t v, logic [4:0] d, string n);
    exp_t x;
    drive(v, d);
    #3;
    if (v.chk_alu) begin
      chk({n, "_aluop"}, 32'(alu_ALUop), 32'(v.aop));
      chk({n, "_alu_a"}, alu_A, v.a);
    end
    chk({n, "_in_ready"}, 32'(in_ready), 1);
    x.res = v.res; x.chk_res = v.chk_res; x.dest = d;
    x.mem = v.mem; x.br = v.br; x.trap = v.trap;
    q.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: compare each bundle the downstream accepts
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        if (e.chk_res) chk("out_result", out_result, e.res);
        chk("out_dest", 32'(out_dest), 32'(e.dest));
        chk("out_is_mem", 32'(out_is_mem), 32'(e.mem));
        chk("out_branch", 32'(out_branch_taken), 32'(e.br));
        chk("out_trap", 32'(out_trap), 32'(e.trap));
      end
    end
  end

  initial begin
    vt[0]  = mk(6'h00, 6'h21, 0, 0, 32'h7FFFFFFF, 1,
                32'h7FFFFFFF, 4'b0010, 1, 32'h80000000, 1, 0, 0, 0);
    vt[1]  = mk(6'h0F, 0, 0, 16'h1234, 32'hDEAD, 0,
                32'd16, 4'b0011, 1, 32'h12340000, 1, 0, 0, 0);
    vt[2]  = mk(6'h00, 6'h03, 5'd4, 0, 0, 32'h80000000,
                32'd4, 4'b0100, 1, 32'hF8000000, 1, 0, 0, 0);
    vt[3]  = mk(6'h00, 6'h2B, 0, 0, 32'hFFFFFFFF, 1,
                0, 0, 0, 32'd0, 1, 0, 0, 0);
    vt[4]  = mk(6'h00, 6'h2A, 0, 0, 32'hFFFFFFFF, 1,
                32'hFFFFFFFF, 4'b0111, 1, 32'd1, 1, 0, 0, 0);
    vt[5]  = mk(6'h0B, 0, 0, 16'hFFFF, 0, 0,
                0, 0, 0, 32'd1, 1, 0, 0, 0);
    vt[6]  = mk(6'h04, 0, 0, 0, 32'd5, 32'd5,
                32'd5, 4'b0110, 1, 32'd0, 1, 0, 1, 0);
    vt[7]  = mk(6'h05, 0, 0, 0, 32'd5, 32'd5,
                32'd5, 4'b0110, 1, 32'd0, 1, 0, 0, 0);
    vt[8]  = mk(6'h23, 0, 0, 16'hFFFC, 32'h1000, 0,
                32'h1000, 4'b0010, 1, 32'h0FFC, 1, 1, 0, 0);
    vt[9]  = mk(6'h2B, 0, 0, 16'h0010, 32'h2000, 0,
                32'h2000, 4'b0010, 1, 32'h2010, 1, 1, 0, 0);
    vt[10] = mk(6'h0C, 0, 0, 16'hF0FF, 32'hFFFF0F0F, 0,
                32'hFFFF0F0F, 4'b0000, 1, 32'h0000000F, 1, 0, 0, 0);
    vt[11] = mk(6'h0D, 0, 0, 16'h8001, 32'h12340000, 0,
                32'h12340000, 4'b0001, 1, 32'h12348001, 1, 0, 0, 0);
    vt[12] = mk(6'h00, 6'h26, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00,
                32'hF0F0F0F0, 4'b1000, 1, 32'h0FF00FF0, 1, 0, 0, 0);
    vt[13] = mk(6'h00, 6'h04, 0, 0, 32'h24, 32'd1,
                32'h24, 4'b0011, 1, 32'h10, 1, 0, 0, 0);
    vt[14] = mk(6'h00, 6'h02, 5'd8, 0, 0, 32'h80000000,
                32'd8, 4'b0101, 1, 32'h00800000, 1, 0, 0, 0);
    vt[15] = mk(6'h00, 6'h23, 0, 0, 32'h80000000, 32'd1,
                32'h80000000, 4'b0110, 1, 32'h7FFFFFFF, 1, 0, 0, 0);
    vt[16] = mk(6'h09, 0, 0, 16'h0001, 32'h7FFFFFFF, 0,
                32'h7FFFFFFF, 4'b0010, 1, 32'h80000000, 1, 0, 0, 0);
    vt[17] = mk(6'h0A, 0, 0, 16'hFFFF, 32'hFFFFFFFE, 0,
                32'hFFFFFFFE, 4'b0111, 1, 32'd1, 1, 0, 0, 0);
    vt[18] = mk(6'h3F, 0, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h7FFFFFFF, 4'b0010, 1, 32'd0, 0, 0, 0, 0);
    vt[19] = mk(6'h00, 6'h24, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0,
                32'hF0F0F0F0, 4'b0000, 1, 32'h00F000F0, 1, 0, 0, 0);
    vtrap  = mk(6'h00, 6'h20, 0, 0, 32'h7FFFFFFF, 32'd1,
                32'h7FFFFFFF, 4'b0010, 1, 32'h80000000, 1, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_dest", 32'(out_dest), 0);
    chk("rst_out_is_mem", 32'(out_is_mem), 0);
    chk("rst_out_branch", 32'(out_branch_taken), 0);
    chk("rst_out_trap", 32'(out_trap), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 20; i++)
      send(vt[i], 5'(i + 1), $sformatf("vec%0d", i));
    @(posedge clk); #1;
    chk("table_drained", 32'(out_valid), 0);

    // flush beats a same-cycle transfer
    drive(vt[0], 5'd21);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_kill_valid", 32'(out_valid), 0);

    // overflow trap halts until flush
    send(vtrap, 5'd22, "trap");
    chk("halt_in_ready", 32'(in_ready), 0);
    drive(vt[0], 5'd23);
    @(posedge clk); #1;
    chk("halt_drained", 32'(out_valid), 0);
    chk("halt_in_ready2", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("halt_no_load", 32'(out_valid), 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);

    // backpressure, then drain and load together
    out_ready = 1'b0;
    send(vt[1], 5'd7, "bp_a");
    vb = vt[12];
    drive(vb, 5'd8);
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold_result", out_result, 32'h12340000);
      chk("bp_hold_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(vb, 5'd8, "bp_b");
    chk("bp_valid_stays", 32'(out_valid), 1);
    chk("bp_new_result", out_result, 32'h0FF00FF0);
    @(posedge clk); #1;
    chk("bp_final_drain", 32'(out_valid), 0);

    // reset while holding a stalled bundle
    out_ready = 1'b0;
    send(vt[8], 5'd9, "rst_hold");
    chk("rst_hold_valid", 32'(out_valid), 1);
    rst = 1'b1;
    void'(q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_out_result", out_result, 0);
    chk("rst2_out_dest", 32'(out_dest), 0);
    chk("rst2_out_is_mem", 32'(out_is_mem), 0);
    chk("rst2_out_trap", 32'(out_trap), 0);
    chk("rst2_in_ready", 32'(in_ready), 1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
